// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, the register-address type and the busy-vector
// popcount helper used by the regfile_sb register file and its scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Widest busy vector the popcount helper handles (ADDR_W up to 10).
  localparam int POP_MAX_W = 1024;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  // Number of set bits in a (zero-extended) busy vector.
  function automatic int unsigned busy_popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned cnt;
    cnt = 32'd0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy bits for issued-but-not-written-back
// destinations. Owns the issue handshake, flush/set/clear priority and the
// registered count of pending destinations.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_issue_valid,
  input  logic [ADDR_W-1:0]      i_issue_addr,
  input  logic                   i_write_reg,
  input  logic [ADDR_W-1:0]      i_w_addr,
  input  logic                   i_flush,
  output logic                   o_issue_ready,
  output logic [2**ADDR_W-1:0]   o_busy,
  output logic [ADDR_W:0]        o_pending_cnt
);

  localparam int   DEPTH = 2**ADDR_W;
  localparam int   CNT_W = ADDR_W + 1;
  localparam logic ZR    = (ZERO_REG != 32'sd0);

  logic [DEPTH-1:0]     r_busy;
  logic [DEPTH-1:0]     w_busy_nxt;
  logic [POP_MAX_W-1:0] w_busy_ext;
  logic [CNT_W-1:0]     r_pending_cnt;
  logic                 w_issue_ready;
  logic                 w_issue_acc;

  // A retiring producer at the same address frees the slot for a WAW issue.
  assign w_issue_ready = ~r_busy[i_issue_addr] | (i_write_reg & (i_w_addr == i_issue_addr));
  assign w_issue_acc   = i_issue_valid & w_issue_ready;

  // Next busy vector: flush beats everything, an accepted issue beats a writeback clear.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_flush) begin
      w_busy_nxt = '0;
    end else begin
      if (i_write_reg) begin
        w_busy_nxt[i_w_addr] = 1'b0;
      end else begin
        w_busy_nxt = w_busy_nxt;
      end
      if (w_issue_acc) begin
        w_busy_nxt[i_issue_addr] = 1'b1;
      end else begin
        w_busy_nxt = w_busy_nxt;
      end
    end
    if (ZR) begin
      w_busy_nxt[0] = 1'b0;
    end else begin
      w_busy_nxt = w_busy_nxt;
    end
  end

  // Zero-extend the next-state vector to the popcount helper's width.
  always_comb begin
    w_busy_ext = '0;
    w_busy_ext[DEPTH-1:0] = w_busy_nxt;
  end

  // Busy bits and their population count advance together on each edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy        <= '0;
      r_pending_cnt <= '0;
    end else begin
      r_busy        <= w_busy_nxt;
      r_pending_cnt <= CNT_W'(busy_popcount(w_busy_ext));
    end
  end

  assign o_issue_ready = w_issue_ready;
  assign o_busy        = r_busy;
  assign o_pending_cnt = r_pending_cnt;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with an issue scoreboard for RAW/WAW
// hazard detection. Optional write-through forwarding is enabled by defining
// the macro REGFILE_BYPASS_EN; the default build reads stored contents only.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] R_Addr_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  output logic [DATA_W-1:0] R_Data_A,
  output logic [DATA_W-1:0] R_Data_B,
  output logic              Busy_A,
  output logic              Busy_B,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic [DATA_W-1:0] W_Data,
  input  logic              Write_Reg,
  input  logic              Issue_Valid,
  input  logic [ADDR_W-1:0] Issue_Addr,
  output logic              Issue_Ready,
  input  logic              Flush,
  output logic [ADDR_W:0]   Pending_Cnt
);

  localparam int   DEPTH = 2**ADDR_W;
  localparam logic ZR    = (ZERO_REG != 32'sd0);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic              w_wr_en;
  logic              w_hit_a;
  logic              w_hit_b;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .i_clk         (Clk),
    .i_rst_n       (Reset_n),
    .i_issue_valid (Issue_Valid),
    .i_issue_addr  (Issue_Addr),
    .i_write_reg   (Write_Reg),
    .i_w_addr      (W_Addr),
    .i_flush       (Flush),
    .o_issue_ready (Issue_Ready),
    .o_busy        (w_busy),
    .o_pending_cnt (Pending_Cnt)
  );

  // Writes to the hardwired zero register are dropped.
  assign w_wr_en = Write_Reg & ~(ZR & (W_Addr == '0));

  // Storage: whole array cleared by reset, one register written per edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[W_Addr] <= W_Data;
    end
  end

  // Forwarding hits: a same-cycle writeback to the read address (zero reg excluded via w_wr_en).
  always_comb begin
    w_hit_a = 1'b0;
    w_hit_b = 1'b0;
`ifdef REGFILE_BYPASS_EN
    w_hit_a = w_wr_en & (W_Addr == R_Addr_A);
    w_hit_b = w_wr_en & (W_Addr == R_Addr_B);
`endif
  end

  // Read port A: zero register, forwarded write data, or stored contents.
  always_comb begin
    w_rd_a = r_mem[R_Addr_A];
    if (ZR && (R_Addr_A == '0)) begin
      w_rd_a = '0;
    end else if (w_hit_a) begin
      w_rd_a = W_Data;
    end else begin
      w_rd_a = r_mem[R_Addr_A];
    end
  end

  // Read port B: same selection as port A.
  always_comb begin
    w_rd_b = r_mem[R_Addr_B];
    if (ZR && (R_Addr_B == '0)) begin
      w_rd_b = '0;
    end else if (w_hit_b) begin
      w_rd_b = W_Data;
    end else begin
      w_rd_b = r_mem[R_Addr_B];
    end
  end

  assign R_Data_A = w_rd_a;
  assign R_Data_B = w_rd_b;
  // A forwarded read already carries the produced value, so it is not busy.
  assign Busy_A   = w_busy[R_Addr_A] & ~w_hit_a;
  assign Busy_B   = w_busy[R_Addr_B] & ~w_hit_b;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb. Expected values
// are queued when stimulus is applied and popped when the output is sampled.
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              Clk;
  logic              Reset_n;
  logic [ADDR_W-1:0] R_Addr_A, R_Addr_B, W_Addr, Issue_Addr;
  logic [DATA_W-1:0] R_Data_A, R_Data_B, W_Data;
  logic              Busy_A, Busy_B, Write_Reg, Issue_Valid, Issue_Ready, Flush;
  logic [ADDR_W:0]   Pending_Cnt;

  logic [63:0] exp_q[$];
  int          n_cmp;
  int          n_mis;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .R_Addr_A    (R_Addr_A),
    .R_Addr_B    (R_Addr_B),
    .R_Data_A    (R_Data_A),
    .R_Data_B    (R_Data_B),
    .Busy_A      (Busy_A),
    .Busy_B      (Busy_B),
    .W_Addr      (W_Addr),
    .W_Data      (W_Data),
    .Write_Reg   (Write_Reg),
    .Issue_Valid (Issue_Valid),
    .Issue_Addr  (Issue_Addr),
    .Issue_Ready (Issue_Ready),
    .Flush       (Flush),
    .Pending_Cnt (Pending_Cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] expv;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=<queue empty>", tag, obs);
    end else begin
      expv = exp_q.pop_front();
      assert (obs === expv) else begin
        n_mis++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
    end
  endtask

  task automatic idle();
    Write_Reg   = 1'b0;
    Issue_Valid = 1'b0;
    Flush       = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    Reset_n = 1'b0;
    R_Addr_A = 5'd5; R_Addr_B = 5'd0; W_Addr = 5'd0; W_Data = 32'd0;
    Issue_Addr = 5'd7;
    idle();
    repeat (3) tick();

    // Reset state
    push(64'd0); check("rst_pending", 64'(Pending_Cnt));
    push(64'd0); check("rst_rdata_a", 64'(R_Data_A));
    push(64'd0); check("rst_busy_a", 64'(Busy_A));
    push(64'd1); check("rst_issue_ready", 64'(Issue_Ready));
    Reset_n = 1'b1;
    tick();
    R_Addr_A = 5'd9; #1;
    push(64'd0); check("post_rst_read_r9", 64'(R_Data_A));

    // Write r5, read back one edge later
    W_Addr = 5'd5; W_Data = 32'hDEADBEEF; Write_Reg = 1'b1;
    push(64'hDEADBEEF);
    tick(); idle(); R_Addr_A = 5'd5; #1;
    check("wr_r5", 64'(R_Data_A));

    // Write r0 is dropped
    W_Addr = 5'd0; W_Data = 32'h1234; Write_Reg = 1'b1;
    push(64'd0);
    tick(); idle(); R_Addr_A = 5'd0; #1;
    check("wr_r0_dropped", 64'(R_Data_A));

    // RAW: issue r7
    Issue_Addr = 5'd7; Issue_Valid = 1'b1; #1;
    push(64'd1); check("issue_r7_ready", 64'(Issue_Ready));
    push(64'd1); push(64'd1);
    tick(); idle(); R_Addr_A = 5'd7; #1;
    check("raw_busy_r7", 64'(Busy_A));
    check("raw_pending_1", 64'(Pending_Cnt));

    // Writeback r7 = 0x55: same-cycle view depends on forwarding
    W_Addr = 5'd7; W_Data = 32'h55; Write_Reg = 1'b1; #1;
    push(BYP ? 64'd0 : 64'd1);    check("wb_r7_busy_same_cycle", 64'(Busy_A));
    push(BYP ? 64'h55 : 64'd0);   check("wb_r7_data_same_cycle", 64'(R_Data_A));
    push(64'd0); push(64'd0); push(64'h55);
    tick(); idle(); #1;
    check("wb_r7_busy_after", 64'(Busy_A));
    check("wb_r7_pending_0", 64'(Pending_Cnt));
    check("wb_r7_data_after", 64'(R_Data_A));

    // WAW: r3 busy blocks a new issue unless it retires this cycle
    Issue_Addr = 5'd3; Issue_Valid = 1'b1;
    tick(); idle(); #1;
    push(64'd0); check("waw_blocked", 64'(Issue_Ready));
    push(64'd1); check("waw_pending_1", 64'(Pending_Cnt));
    W_Addr = 5'd3; W_Data = 32'h33; Write_Reg = 1'b1; Issue_Valid = 1'b1; #1;
    push(64'd1); check("waw_retire_ready", 64'(Issue_Ready));
    push(64'd1); push(64'd1); push(64'h33);
    tick(); idle(); R_Addr_A = 5'd3; #1;
    check("waw_busy_kept", 64'(Busy_A));
    check("waw_pending_same", 64'(Pending_Cnt));
    check("waw_data", 64'(R_Data_A));
    W_Addr = 5'd3; Write_Reg = 1'b1;
    push(64'd0);
    tick(); idle(); #1;
    check("r3_retired_pending_0", 64'(Pending_Cnt));

    // Flush: beats a simultaneous issue, register write still lands
    Issue_Valid = 1'b1;
    Issue_Addr = 5'd1; tick();
    Issue_Addr = 5'd2; tick();
    Issue_Addr = 5'd4; tick();
    idle(); #1;
    push(64'd3); check("flush_pre_pending_3", 64'(Pending_Cnt));
    Flush = 1'b1; Issue_Valid = 1'b1; Issue_Addr = 5'd9;
    Write_Reg = 1'b1; W_Addr = 5'd2; W_Data = 32'hA;
    push(64'd0); push(64'd0); push(64'd0); push(64'hA);
    tick(); idle(); R_Addr_A = 5'd2; R_Addr_B = 5'd9; #1;
    check("flush_pending_0", 64'(Pending_Cnt));
    check("flush_busy_r2", 64'(Busy_A));
    check("flush_busy_r9", 64'(Busy_B));
    check("flush_data_r2", 64'(R_Data_A));
    R_Addr_A = 5'd4; #1;
    push(64'd0); check("flush_busy_r4", 64'(Busy_A));

    // Forwarding on port B with r6 busy
    Issue_Addr = 5'd6; Issue_Valid = 1'b1;
    tick(); idle();
    R_Addr_B = 5'd6; W_Addr = 5'd6; W_Data = 32'hCAFE; Write_Reg = 1'b1; #1;
    push(BYP ? 64'hCAFE : 64'd0); check("byp_data_b", 64'(R_Data_B));
    push(BYP ? 64'd0 : 64'd1);    check("byp_busy_b", 64'(Busy_B));
    push(64'hCAFE); push(64'd0);
    tick(); idle(); #1;
    check("byp_data_b_after", 64'(R_Data_B));
    check("byp_busy_b_after", 64'(Busy_B));

    // Zero register is never forwarded
    R_Addr_A = 5'd0; W_Addr = 5'd0; W_Data = 32'h77; Write_Reg = 1'b1; #1;
    push(64'd0); check("r0_no_forward", 64'(R_Data_A));
    tick(); idle();

    // Pending count saturates at DEPTH-1 when every address is issued
    Issue_Valid = 1'b1;
    for (int a = 0; a < 32; a++) begin
      Issue_Addr = a[ADDR_W-1:0];
      tick();
    end
    idle(); R_Addr_A = 5'd0; #1;
    push(64'd31); check("all_issued_pending_31", 64'(Pending_Cnt));
    push(64'd0);  check("r0_never_busy", 64'(Busy_A));
    Flush = 1'b1;
    tick(); idle(); #1;
    push(64'd0); check("flush_all_pending_0", 64'(Pending_Cnt));

    // Mid-cycle async reset with r10 busy and written
    Issue_Addr = 5'd10; Issue_Valid = 1'b1;
    W_Addr = 5'd10; W_Data = 32'h77; Write_Reg = 1'b1;
    push(64'd1); push(64'h77); push(64'd1);
    tick(); idle(); R_Addr_A = 5'd10; #1;
    check("r10_busy", 64'(Busy_A));
    check("r10_data", 64'(R_Data_A));
    check("r10_pending_1", 64'(Pending_Cnt));
    #1 Reset_n = 1'b0;
    #1;
    push(64'd0); check("midrst_pending_0", 64'(Pending_Cnt));
    push(64'd0); check("midrst_data_r10", 64'(R_Data_A));
    push(64'd0); check("midrst_busy_r10", 64'(Busy_A));
    push(64'd1); check("midrst_issue_ready", 64'(Issue_Ready));
    #1 Reset_n = 1'b1;
    tick();

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL leftover_expectations observed=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with an integrated issue scoreboard, for the pipelined CPU datapath. It provides two asynchronous read ports and one synchronous write port. A busy bit per register tracks destinations that have been issued but not yet written back. Busy status is exported for each read address so decode can stall on RAW hazards.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never marked busy

Ports:
- Clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous, active-low reset
- R_Addr_A  input  ADDR_W  read port A address
- R_Addr_B  input  ADDR_W  read port B address
- R_Data_A  output  DATA_W  read port A data (combinational)
- R_Data_B  output  DATA_W  read port B data (combinational)
- Busy_A  output  1  register at R_Addr_A has a pending write
- Busy_B  output  1  register at R_Addr_B has a pending write
- W_Addr  input  ADDR_W  writeback address
- W_Data  input  DATA_W  writeback data
- Write_Reg  input  1  writeback strobe
- Issue_Valid  input  1  request to reserve Issue_Addr as a destination
- Issue_Addr  input  ADDR_W  destination being issued
- Issue_Ready  output  1  issue is accepted this cycle
- Flush  input  1  synchronous clear of all busy bits
- Pending_Cnt  output  ADDR_W+1  number of busy registers (registered)

## Operation
- Reset (Reset_n low, asynchronous) has these effects:
  - All registers, all busy bits and Pending_Cnt are 0.
  - R_Data_A/B therefore read 0, Busy_A/B read 0 and Issue_Ready reads 1.
- A write occurs at the rising edge of Clk when Write_Reg=1: REG[W_Addr] <= W_Data. With ZERO_REG=1, a write to address 0 is dropped.
- Reads are combinational: R_Data_X = REG[R_Addr_X]. With ZERO_REG=1, address 0 always returns 0.
- Issue_Ready = ~busy[Issue_Addr] | (Write_Reg & W_Addr==Issue_Addr). This blocks a WAW issue unless the previous producer retires in the same cycle.
- An issue is accepted when Issue_Valid & Issue_Ready. At the next edge, busy[Issue_Addr] <= 1. With ZERO_REG=1, an issue to address 0 is accepted but sets nothing.
- A writeback with Write_Reg=1 clears busy[W_Addr] at the next edge.
- If an accepted issue and a writeback target the same address in the same cycle, the set wins and the busy bit stays 1 for the new producer.
- Flush=1 clears every busy bit at the next edge and overrides a simultaneous issue. A register write in the same cycle still lands.
- Pending_Cnt is updated each edge to the population count of the next-state busy vector. It never exceeds DEPTH-ZERO_REG.
- Busy_X = busy[R_Addr_X], subject to the bypass modification described under Configuration.

## Timing
- Read latency is 0 cycles (combinational). Write and busy-update latency is 1 edge.
- A write at edge N is visible on the read ports after edge N.
- Without bypass, a read of W_Addr in the writeback cycle returns the old value and Busy stays 1 for that cycle.
- Reset asserted mid-operation clears all state immediately. It takes effect independent of Clk and discards any pending issue or write.
- Issue_Ready and Busy_A/B are combinational from the addresses, Write_Reg and W_Addr. They have no dependence on Issue_Valid, so there is no combinational loop.

## Configuration
- Macro REGFILE_BYPASS_EN enables write-through forwarding.
- Defined: when Write_Reg=1 and W_Addr==R_Addr_X (excluding address 0 with ZERO_REG=1):
  - R_Data_X = W_Data.
  - Busy_X = 0 in the same cycle.
- Undefined: reads return stored contents only, and busy deasserts one cycle after writeback.
- Scoreboard update rules are identical in both builds.

## Structure
- Package regfile_pkg holds the following:
  - Default DATA_W/ADDR_W constants.
  - The typedef for a register-address word.
  - The function for the popcount of the busy vector.
- Sub-module reg_scoreboard holds:
  - The busy vector.
  - The Issue_Ready, Flush and set/clear priority logic.
  - Pending_Cnt.
- Storage and read muxes/bypass stay in regfile_sb.

## Test plan
- Reset value and write/read: hold Reset_n low, then release. Read any address and expect 0. Write 0xDEADBEEF to r5 and expect R_Data_A=0xDEADBEEF with R_Addr_A=5 one edge later. Write 0x1234 to r0 and expect r0 to read 0.
- Scoreboard RAW: issue r7. The next cycle must show Busy_A=1 for R_Addr_A=7 and Pending_Cnt=1. Write back r7=0x55 and expect Busy_A=0, Pending_Cnt=0 and data 0x55 after the edge.
- WAW and simultaneity: with r3 busy and no writeback, expect Issue_Ready=0 for r3. Present a writeback of r3 and an issue of r3 together. Expect Issue_Ready=1 and busy r3 still 1 afterwards, with Pending_Cnt unchanged.
- Flush: issue r1, r2 and r4, so Pending_Cnt=3. Assert Flush together with an issue of r9 and a write r2=0xA. Expect Pending_Cnt=0, all Busy low and r2=0xA.
- Bypass (REGFILE_BYPASS_EN): write r6=0xCAFE with R_Addr_B=6 in the same cycle. Expect R_Data_B=0xCAFE and Busy_B=0 before the edge. Without the macro, expect the old value and Busy_B=1 until the edge.
- Mid-operation reset: with r10 busy and data nonzero, pulse Reset_n low between edges. Expect an immediate Pending_Cnt=0 and r10 reading 0.
